// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
// Contents: instruction class codes, FSM state encoding, one-hot bus/enable
// constants, instruction field positions and the opcode decode helper.
package instr_sequencer_pkg;

  localparam int unsigned SelW = 11;

  typedef enum logic [2:0] {
    ClsLoad = 3'b000,
    ClsMove = 3'b001,
    ClsAdd  = 3'b010,
    ClsSub  = 3'b011,
    ClsOr   = 3'b100,
    ClsAnd  = 3'b101,
    ClsOnes = 3'b110,
    ClsTwos = 3'b111
  } instr_class_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StT1   = 2'd1,
    StT2   = 2'd2,
    StT3   = 2'd3
  } state_e;

  // One-hot bus driver / write-enable positions.
  localparam logic [SelW-1:0] SEL_DIN = 11'h001;
  localparam logic [SelW-1:0] SEL_G   = 11'h002;
  localparam logic [SelW-1:0] SEL_A   = 11'h004;
  localparam logic [SelW-1:0] SEL_R0  = 11'h008;
  localparam logic [SelW-1:0] SEL_R1  = 11'h010;
  localparam logic [SelW-1:0] SEL_R2  = 11'h020;
  localparam logic [SelW-1:0] SEL_R3  = 11'h040;
  localparam logic [SelW-1:0] SEL_R4  = 11'h080;
  localparam logic [SelW-1:0] SEL_R5  = 11'h100;
  localparam logic [SelW-1:0] SEL_R6  = 11'h200;
  localparam logic [SelW-1:0] SEL_R7  = 11'h400;

  // Instruction word field positions.
  localparam int unsigned OpHi = 15;
  localparam int unsigned OpLo = 9;
  localparam int unsigned XHi  = 8;
  localparam int unsigned XLo  = 6;
  localparam int unsigned YHi  = 5;
  localparam int unsigned YLo  = 3;

  // Returns {legal, class}. ALU opcodes are 100_0xxx with xxx in 010..111.
  function automatic logic [3:0] decode_op(input logic [6:0] op);
    logic [3:0] res;
    res = 4'b0000;
    if (op == 7'b000_0000) begin
      res = {1'b1, ClsLoad};
    end else if (op == 7'b000_0001) begin
      res = {1'b1, ClsMove};
    end else if (op[6:3] == 4'b1000 && op[2:1] != 2'b00) begin
      res = {1'b1, op[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/instr_sequencer_reg_select_decoder.sv
// reg_select_decoder: maps a 3-bit register index to the one-hot R0-R7
// pattern (bits 3..10) of the bus-select / register-enable vectors.
// Ports: idx (register index), onehot (SEL_WIDTH one-hot pattern).
module reg_select_decoder
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned SEL_WIDTH = 11
) (
  input  logic [2:0]           idx,
  output logic [SEL_WIDTH-1:0] onehot
);

  always_comb begin
    onehot = SEL_WIDTH'(SEL_R0) << idx;
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-step control FSM for the register/ALU datapath.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   run          - start request, sampled in IDLE with stepEn high
//   stepEn       - advance qualifier; state and writes move only when high
//   din          - instruction word in IDLE
//   busSelect    - one-hot bus driver (DIN, G, -, R0..R7)
//   regEnable    - one-hot write enable (-, G, A, R0..R7), gated by stepEn
//   aluOp        - instruction class while an instruction is in flight
//   busy         - high in T1..T3
//   done         - final step of an instruction with stepEn high
//   illegal      - one-cycle pulse after a rejected opcode
//   instrCount   - wrapping count of completed instructions
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SEL_WIDTH   = 11,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   stepEn,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [SEL_WIDTH-1:0]   busSelect,
  output logic [SEL_WIDTH-1:0]   regEnable,
  output logic [2:0]             aluOp,
  output logic                   busy,
  output logic                   done,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instrCount
);

  state_e                 state_q, state_d;
  logic [8:0]             ir_q, ir_d;       // {class, XXX, YYY}
  logic                   illegal_q, illegal_d;
  logic [COUNT_WIDTH-1:0] count_q;

  logic [SEL_WIDTH-1:0]   rx_sel, ry_sel, en_raw;
  logic [3:0]             dec;
  logic                   last_step;
  instr_class_e           cls;

  logic unused_din;
  assign unused_din = ^din[YLo-1:0];

  assign cls = instr_class_e'(ir_q[8:6]);
  assign dec = decode_op(din[OpHi:OpLo]);

  reg_select_decoder #(.SEL_WIDTH(SEL_WIDTH)) u_dec_x (
    .idx    (ir_q[5:3]),
    .onehot (rx_sel)
  );

  reg_select_decoder #(.SEL_WIDTH(SEL_WIDTH)) u_dec_y (
    .idx    (ir_q[2:0]),
    .onehot (ry_sel)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = 1'b0;
    busSelect = '0;
    en_raw    = '0;
    aluOp     = 3'b000;
    busy      = 1'b0;
    last_step = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run && stepEn) begin
          if (dec[3]) begin
            ir_d    = {dec[2:0], din[XHi:XLo], din[YHi:YLo]};
            state_d = StT1;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StT1: begin
        busy  = 1'b1;
        aluOp = cls;
        unique case (cls)
          ClsLoad: begin
            busSelect = SEL_WIDTH'(SEL_DIN);
            en_raw    = rx_sel;
            last_step = 1'b1;
          end
          ClsMove: begin
            busSelect = ry_sel;
            en_raw    = rx_sel;
            last_step = 1'b1;
          end
          ClsOnes, ClsTwos: begin
            busSelect = ry_sel;
            en_raw    = SEL_WIDTH'(SEL_A);
          end
          default: begin
            busSelect = rx_sel;
            en_raw    = SEL_WIDTH'(SEL_A);
          end
        endcase
        if (stepEn) state_d = last_step ? StIdle : StT2;
      end
      StT2: begin
        busy  = 1'b1;
        aluOp = cls;
        // Complements operate on A alone, so nothing drives the bus here.
        busSelect = (cls == ClsOnes || cls == ClsTwos) ? '0 : ry_sel;
        en_raw    = SEL_WIDTH'(SEL_G);
        if (stepEn) state_d = StT3;
      end
      StT3: begin
        busy      = 1'b1;
        aluOp     = cls;
        busSelect = SEL_WIDTH'(SEL_G);
        en_raw    = rx_sel;
        last_step = 1'b1;
        if (stepEn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign regEnable  = stepEn ? en_raw : '0;
  assign done       = last_step & stepEn;
  assign illegal    = illegal_q;
  assign instrCount = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      if (done) count_q <= count_q + 1'b1;
    end
  end

endmodule
